seven_seg_scanner: RTL



---
 rtl/seg_pkg.sv | 46 ++++
 rtl/seven_seg_scanner_if.sv | 33 +++
 rtl/bcd_to_seg.sv | 25 ++
 rtl/seven_seg_scanner.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions used by every display block.
// Contents:
//   SEG_OFF               all segments dark, in active-low pin polarity
//   SEG_A_BIT..SEG_DP_BIT bit positions in the {dp,g,f,e,d,c,b,a} segment byte
//   GLYPH_0..GLYPH_9      active-high {g..a} patterns for the decimal digits
//   GLYPH_DASH            active-high marker for non-BCD codes (only g lit)
//   bcd_glyph()           4-bit code -> active-high 7-segment glyph
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam int SEG_A_BIT  = 0;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;

  function automatic logic [6:0] bcd_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bundle between the digit source (counter / top level) and the scanner.
// Signals:
//   digits     packed BCD, digit 0 in bits [3:0] (rightmost)
//   digit_en   per-digit light enable
//   dp         per-digit decimal point
//   blank_lz   leading-zero blanking enable
//   an         active-low anodes toward the board
//   seg        active-low {dp,g,f,e,d,c,b,a} toward the board
//   frame_done one-cycle pulse at the end of the last digit slot
// Modports: master = digit source, slave = scanner.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic                    frame_done;

  modport master (
    output digits, digit_en, dp, blank_lz,
    input  an, seg, frame_done
  );

  modport slave (
    input  digits, digit_en, dp, blank_lz,
    output an, seg, frame_done
  );

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder with active-low output.
// Ports:
//   code   in  4  BCD code; 10..15 render as a dash
//   dp     in  1  decimal point lit
//   blank  in  1  force the whole digit dark (dp included)
//   seg_n  out 8  {dp,g,f,e,d,c,b,a}, active-low
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_n
);

  logic [7:0] lit;

  always_comb begin
    lit                       = '0;
    lit[SEG_G_BIT:SEG_A_BIT]  = bcd_glyph(code);
    lit[SEG_DP_BIT]           = dp;
    seg_n                     = blank ? SEG_OFF : ~lit;
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner.
// Snapshots the digit bus once per frame, scans digits 0..NUM_DIGITS-1 one
// slot at a time, keeps every anode off for the first GUARD cycles of a slot
// and drives registered active-low anode / segment pins.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport: digits/digit_en/dp/blank_lz in, an/seg/frame_done out
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100_000,
  parameter int GUARD      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_seg_scanner_if.slave   bus
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [TW-1:0]           timer;
  logic [IW-1:0]           idx;
  logic                    tick;
  logic                    last_slot;
  logic                    frame_end;
  logic                    in_guard;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic                    sh_blz;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_dark;
  logic [7:0]              cur_seg_n;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [7:0]              seg_nxt;

  logic [NUM_DIGITS-1:0]   an_p1;
  logic [7:0]              seg_p1;

  // ---- stage 0: slot timer, digit index, frame shadow ----
  assign tick      = (timer == TW'(SCAN_DIV - 1));
  assign last_slot = (idx == IW'(NUM_DIGITS - 1));
  assign frame_end = tick & last_slot;
  assign in_guard  = (timer < TW'(GUARD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      idx   <= '0;
    end else begin
      timer <= tick ? '0 : timer + 1'b1;
      if (tick) begin
        idx <= last_slot ? '0 : idx + 1'b1;
      end
    end
  end

  // Shadow is reloaded only at the frame boundary, so a frame never mixes
  // old and new input values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_en     <= '0;
      sh_dp     <= '0;
      sh_blz    <= 1'b0;
    end else if (frame_end) begin
      sh_digits <= bus.digits;
      sh_en     <= bus.digit_en;
      sh_dp     <= bus.dp;
      sh_blz    <= bus.blank_lz;
    end
  end

  // Leading-zero mask: walk from the most significant digit down, keeping a
  // running "everything so far is zero" flag. Non-BCD codes break the run.
  // Digit 0 is excluded so a zero value still shows one "0".
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_digits[4*i +: 4] == 4'd0);
      if (i != 0) begin
        blank_vec[i] = sh_blz & zero_run;
      end
    end
  end

  // Current-slot digit; a disabled or blanked digit is fully dark.
  always_comb begin
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_code = sh_digits[4*i +: 4];
        cur_dp   = sh_dp[i];
        cur_dark = ~sh_en[i] | blank_vec[i];
      end
    end
  end

  bcd_to_seg u_dec (
    .code  (cur_code),
    .dp    (cur_dp),
    .blank (cur_dark),
    .seg_n (cur_seg_n)
  );

  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    if (!in_guard) begin
      seg_nxt = cur_seg_n;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) == idx) begin
          an_nxt[i] = cur_dark;
        end
      end
    end
  end

  // ---- stage 1: registered pin drivers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p1  <= '1;
      seg_p1 <= SEG_OFF;
    end else begin
      an_p1  <= an_nxt;
      seg_p1 <= seg_nxt;
    end
  end

  assign bus.an         = an_p1;
  assign bus.seg        = seg_p1;
  assign bus.frame_done = frame_end;

endmodule
